// File: rtl/spm_cisr_sched_if.sv
// Host/channel bundle for the CISR run-level scheduler: job command and status,
// per-channel row requests, bubbles and retire pulses.
interface spm_cisr_sched_if #(
    parameter int NUM_CH = 16,
    parameter int NNZ_W  = 32,
    parameter int DIM_W  = 16
);
    logic              start;
    logic [DIM_W-1:0]  cfg_num_rows;
    logic [NNZ_W-1:0]  cfg_nnz;
    logic [NUM_CH-1:0] row_req;
    logic [NUM_CH-1:0] fetch_bubble;
    logic [NUM_CH-1:0] elem_retire;
    logic              acc_idle;
    logic              spmv_init;
    logic [NUM_CH-1:0] pipe_bubble;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [DIM_W-1:0]  rows_issued;
    logic [NNZ_W-1:0]  nnz_retired;

    modport master (
        output start, cfg_num_rows, cfg_nnz, row_req, fetch_bubble, elem_retire, acc_idle,
        input  spmv_init, pipe_bubble, busy, done, timeout, rows_issued, nnz_retired
    );

    modport slave (
        input  start, cfg_num_rows, cfg_nnz, row_req, fetch_bubble, elem_retire, acc_idle,
        output spmv_init, pipe_bubble, busy, done, timeout, rows_issued, nnz_retired
    );
endinterface

// File: rtl/spm_cisr_sched.sv
// Run-level controller and row-issue limiter for the CISR decoder: sequences one
// SpMV job, caps the number of row lengths popped, tracks retirement and stalls.
module spm_cisr_sched #(
    parameter int NUM_CH      = 16,
    parameter int NNZ_W       = 32,
    parameter int DIM_W       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    spm_cisr_sched_if.slave  bus
);
    localparam int CNT_W   = $clog2(NUM_CH + 1);
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [DIM_W-1:0]   num_rows_r, rows_issued_r, remaining_s;
    logic [NNZ_W-1:0]   nnz_r, nnz_retired_r, nnz_sat_s;
    logic [NNZ_W:0]     nnz_sum_s;
    logic [STALL_W-1:0] stall_r;
    logic               spmv_init_r, busy_r, done_r, timeout_r;
    logic [NUM_CH-1:0]  cand_s, grant_s, pipe_bubble_s;
    logic [CNT_W-1:0]   grant_cnt_s, retire_cnt_s;
    logic               stall_hit_s, any_retire_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Grant the lowest-indexed candidates, never more than the rows still owed.
    function automatic logic [NUM_CH-1:0] limit_grants(input logic [NUM_CH-1:0] cand,
                                                        input logic [DIM_W-1:0]  remaining);
        logic [DIM_W:0]    used;
        logic [NUM_CH-1:0] g;
        used = '0;
        g    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cand[i] && (used < {1'b0, remaining})) begin
                g[i] = 1'b1;
                used = used + {{DIM_W{1'b0}}, 1'b1};
            end else begin
                g[i] = 1'b0;
            end
        end
        return g;
    endfunction

    assign cand_s       = bus.row_req & ~bus.fetch_bubble;
    assign remaining_s  = num_rows_r - rows_issued_r;
    assign retire_cnt_s = popcount(bus.elem_retire);
    assign grant_cnt_s  = popcount(grant_s);
    assign any_retire_s = |bus.elem_retire;
    assign stall_hit_s  = !any_retire_s && (stall_r == STALL_W'(TIMEOUT_CYC - 1));
    assign nnz_sum_s    = {1'b0, nnz_retired_r} + (NNZ_W + 1)'(retire_cnt_s);
    assign nnz_sat_s    = nnz_sum_s[NNZ_W] ? {NNZ_W{1'b1}} : nnz_sum_s[NNZ_W-1:0];

    // Next-state, limiter grants and bubble gating.
    always_comb begin
        state_s       = state_r;
        grant_s       = '0;
        pipe_bubble_s = '1;
        case (state_r)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (bus.start) state_s = S_INIT;
                else           state_s = state_r;
            end
            S_INIT: state_s = S_RUN;
            S_RUN: begin
                grant_s       = limit_grants(cand_s, remaining_s);
                pipe_bubble_s = bus.fetch_bubble | (cand_s & ~grant_s);
                if (stall_hit_s)                       state_s = S_TIMEOUT;
                else if (rows_issued_r == num_rows_r)  state_s = S_DRAIN;
                else                                   state_s = S_RUN;
            end
            S_DRAIN: begin
                pipe_bubble_s = bus.fetch_bubble | bus.row_req;
                // Overshoot (retired > nnz) also terminates; the host must treat it as an error.
                if ((nnz_retired_r >= nnz_r) && bus.acc_idle) state_s = S_DONE;
                else if (stall_hit_s)                         state_s = S_TIMEOUT;
                else                                          state_s = S_DRAIN;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, job configuration, progress counters and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            num_rows_r    <= '0;
            nnz_r         <= '0;
            rows_issued_r <= '0;
            nnz_retired_r <= '0;
            stall_r       <= '0;
            spmv_init_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            spmv_init_r <= (state_s == S_INIT);
            busy_r      <= (state_s == S_INIT) || (state_s == S_RUN) || (state_s == S_DRAIN);
            done_r      <= (state_s == S_DONE);
            timeout_r   <= (state_s == S_TIMEOUT);
            if (((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_TIMEOUT)) && bus.start) begin
                num_rows_r    <= bus.cfg_num_rows;
                nnz_r         <= bus.cfg_nnz;
                rows_issued_r <= '0;
                nnz_retired_r <= '0;
                stall_r       <= '0;
            end else if ((state_r == S_RUN) || (state_r == S_DRAIN)) begin
                nnz_retired_r <= nnz_sat_s;
                stall_r       <= any_retire_s ? '0 : stall_r + STALL_W'(1);
                if (state_r == S_RUN) begin
                    rows_issued_r <= rows_issued_r + DIM_W'(grant_cnt_s);
                end
            end
        end
    end

    assign bus.spmv_init   = spmv_init_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.timeout     = timeout_r;
    assign bus.rows_issued = rows_issued_r;
    assign bus.nnz_retired = nnz_retired_r;
    assign bus.pipe_bubble = pipe_bubble_s;
endmodule

// File: tb/tb_spm_cisr_sched.sv
// Scoreboard bench for spm_cisr_sched: a job-level reference model predicts every
// cycle's outputs, and a monitor compares them against the DUT.
module tb_spm_cisr_sched;
    localparam int NUM_CH = 16;
    localparam int NNZ_W  = 32;
    localparam int DIM_W  = 16;
    localparam int TCYC   = 16;

    localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4, P_TMO = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spm_cisr_sched_if #(.NUM_CH(NUM_CH), .NNZ_W(NNZ_W), .DIM_W(DIM_W)) bus();

    spm_cisr_sched #(.NUM_CH(NUM_CH), .NNZ_W(NNZ_W), .DIM_W(DIM_W), .TIMEOUT_CYC(TCYC)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [NUM_CH-1:0] pb;
        logic              init, busy, done, tmo;
        logic [DIM_W-1:0]  ri;
        logic [NNZ_W-1:0]  nr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (job-level view)
    int     m_phase = P_IDLE;
    bit     m_valid = 1'b0;
    longint m_rows, m_nnz, m_issued, m_retired;
    int     m_stall;

    // Stimulus for the next cycle
    logic              s_rst, s_start, s_idle;
    logic [DIM_W-1:0]  s_rows;
    logic [NNZ_W-1:0]  s_nnz;
    logic [NUM_CH-1:0] s_req, s_fb, s_ret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, push its predicted outputs, then advance the model.
    task automatic tick();
        exp_t              e;
        logic [NUM_CH-1:0] cand, grant;
        longint            k, given;
        int                nret;
        bit                job_done, rows_met;
        @(negedge clk);
        rst_n            = s_rst;
        bus.start        = s_start;
        bus.cfg_num_rows = s_rows;
        bus.cfg_nnz      = s_nnz;
        bus.row_req      = s_req;
        bus.fetch_bubble = s_fb;
        bus.elem_retire  = s_ret;
        bus.acc_idle     = s_idle;

        cand  = s_req & ~s_fb;
        grant = '0;
        given = 0;
        if (m_phase == P_RUN) begin
            k = $countones(cand);
            if (m_rows - m_issued < k) k = m_rows - m_issued;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cand[i] && given < k) begin
                    grant[i] = 1'b1;
                    given++;
                end
            end
        end

        if (m_valid) begin
            if (m_phase == P_RUN)        e.pb = s_fb | (cand & ~grant);
            else if (m_phase == P_DRAIN) e.pb = s_fb | s_req;
            else                         e.pb = '1;
            e.init = (m_phase == P_INIT);
            e.busy = (m_phase == P_INIT) || (m_phase == P_RUN) || (m_phase == P_DRAIN);
            e.done = (m_phase == P_DONE);
            e.tmo  = (m_phase == P_TMO);
            e.ri   = DIM_W'(m_issued);
            e.nr   = NNZ_W'(m_retired);
            exp_q.push_back(e);
        end

        if (!s_rst) begin
            m_valid = 1'b1; m_phase = P_IDLE;
            m_rows = 0; m_nnz = 0; m_issued = 0; m_retired = 0; m_stall = 0;
        end else if (m_valid) begin
            case (m_phase)
                P_IDLE, P_DONE, P_TMO: begin
                    if (s_start) begin
                        m_rows = s_rows; m_nnz = s_nnz;
                        m_issued = 0; m_retired = 0; m_stall = 0;
                        m_phase = P_INIT;
                    end
                end
                P_INIT: m_phase = P_RUN;
                P_RUN, P_DRAIN: begin
                    job_done = (m_phase == P_DRAIN) && (m_retired >= m_nnz) && s_idle;
                    rows_met = (m_phase == P_RUN) && (m_issued == m_rows);
                    if (job_done && m_retired > m_nnz)
                        $display("NOTE: protocol violation, nnz_retired %0d exceeds nnz %0d", m_retired, m_nnz);
                    nret = $countones(s_ret);
                    m_retired = m_retired + nret;
                    if (m_retired > 64'h0000_0000_FFFF_FFFF) m_retired = 64'h0000_0000_FFFF_FFFF;
                    m_stall = (nret > 0) ? 0 : m_stall + 1;
                    if (m_phase == P_RUN) m_issued = m_issued + given;
                    if (job_done)            m_phase = P_DONE;
                    else if (m_stall >= TCYC) m_phase = P_TMO;
                    else if (rows_met)       m_phase = P_DRAIN;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic quiet();
        s_start = 1'b0; s_req = '0; s_fb = '0; s_ret = '0; s_idle = 1'b0;
    endtask

    task automatic start_job(input int rows, input int nnz);
        quiet();
        s_start = 1'b1; s_rows = DIM_W'(rows); s_nnz = NNZ_W'(nnz);
        tick();
        s_start = 1'b0;
    endtask

    // Retire in 4-bit bursts until the count is met, then hold acc_idle low a while.
    task automatic finish_job(input int idle_delay);
        int guard = 0;
        while (m_phase != P_DONE && m_phase != P_TMO && guard < 400) begin
            s_req  = NUM_CH'($urandom);
            s_fb   = NUM_CH'($urandom) & NUM_CH'($urandom);
            s_ret  = (m_retired + 4 <= m_nnz) ? 16'h000F << (4 * $urandom_range(0, 3)) : '0;
            s_idle = 1'b0;
            if (m_retired >= m_nnz) begin
                if (idle_delay > 0) idle_delay--;
                else s_idle = 1'b1;
            end
            tick();
            guard++;
        end
        if (guard >= 400) begin
            n_cmp++; n_bad++;
            $display("FAIL finish_job: job did not finish within 400 cycles");
        end
        quiet();
    endtask

    // Monitor: compares every presented cycle against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pipe_bubble", 64'(bus.pipe_bubble), 64'(e.pb));
            chk("spmv_init",   64'(bus.spmv_init),   64'(e.init));
            chk("busy",        64'(bus.busy),        64'(e.busy));
            chk("done",        64'(bus.done),        64'(e.done));
            chk("timeout",     64'(bus.timeout),     64'(e.tmo));
            chk("rows_issued", 64'(bus.rows_issued), 64'(e.ri));
            chk("nnz_retired", 64'(bus.nnz_retired), 64'(e.nr));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        s_rst = 1'b0; s_rows = '0; s_nnz = '0;
        quiet();
        repeat (3) tick();
        s_rst = 1'b1;
        repeat (2) tick();

        // 40 rows / 120 nnz: init pulse, full-width grants, then 38/40 corner.
        start_job(40, 120);
        s_req = '1; tick();                       // INIT
        s_req = '1; s_fb = '0; tick();            // 16
        tick();                                   // 32
        s_req = 16'h003F; tick();                 // 38
        s_req = 16'h0288; s_fb = 16'h0008; tick(); // ch7, ch9 granted -> 40
        s_req = 16'h0001; s_fb = '0; tick();      // rows met, no grant
        finish_job(3);
        repeat (2) tick();

        // 5 rows, all channels requesting on the first RUN cycle.
        start_job(5, 20);
        tick();
        s_req = '1; tick();
        tick();
        finish_job(0);

        // Zero-row job.
        start_job(0, 8);
        tick();
        s_req = '1; tick();
        finish_job(1);

        // Timeout after TCYC silent cycles, then restart.
        start_job(3, 10);
        tick();
        for (int i = 0; i < TCYC + 2; i++) begin
            s_req = NUM_CH'($urandom); s_ret = '0; tick();
        end
        start_job(2, 4);
        tick();
        s_req = '1; tick();
        finish_job(0);

        // Reset mid-RUN with 12 rows issued; start while busy is ignored.
        start_job(40, 50);
        tick();
        s_req = 16'h0FFF; s_ret = 16'h0001; tick();
        s_req = '0; s_start = 1'b1; s_rows = 16'd7; tick();
        s_start = 1'b0; s_rst = 1'b0; tick();
        s_rst = 1'b1; tick(); tick();

        // Randomised jobs with occasional stray starts.
        for (int j = 0; j < 10; j++) begin
            start_job($urandom_range(0, 50), $urandom_range(0, 80));
            guard = 0;
            while (guard < 300 && !((m_phase == P_DONE || m_phase == P_TMO) && guard > 2)) begin
                s_req   = NUM_CH'($urandom);
                s_fb    = NUM_CH'($urandom) & NUM_CH'($urandom);
                s_ret   = ($urandom_range(0, 9) == 0) ? '0
                          : NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom);
                s_idle  = ($urandom_range(0, 3) != 0);
                s_start = ($urandom_range(0, 19) == 0);
                s_rows  = DIM_W'($urandom_range(0, 50));
                tick();
                guard++;
            end
            quiet();
            tick();
        end

        quiet();
        repeat (3) tick();
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #5;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
